// File: rtl/fb_pc_gen_if.sv
// Fetch-side bundle between the Firebird IF stage and the PC generator.
// FB_PC_ALIGN_CHECK_EN adds the misalign_err status line.
interface fb_pc_gen_if #(
  parameter int XLEN = 32
);
  logic            pc_stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            flush;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_next_seq;
  logic            clear_inst;
  logic            redirect_pending;
`ifdef FB_PC_ALIGN_CHECK_EN
  logic            misalign_err;
`endif

  modport master (
    output pc_stall,
    output redirect_valid,
    output redirect_addr,
    output flush,
`ifdef FB_PC_ALIGN_CHECK_EN
    input  misalign_err,
`endif
    input  pc_out,
    input  pc_next_seq,
    input  clear_inst,
    input  redirect_pending
  );

  modport slave (
    input  pc_stall,
    input  redirect_valid,
    input  redirect_addr,
    input  flush,
`ifdef FB_PC_ALIGN_CHECK_EN
    output misalign_err,
`endif
    output pc_out,
    output pc_next_seq,
    output clear_inst,
    output redirect_pending
  );
endinterface

// File: rtl/fb_pc_gen.sv
// Firebird IF-stage program counter with stall-safe redirect buffering and bubble counter.
// Define FB_PC_ALIGN_CHECK_EN to word-align redirect targets and flag misaligned ones.
//
// state   | meaning
// ST_RUN  | no buffered redirect; PC steps, holds or takes a live redirect
// ST_PEND | redirect captured during a stall, applied when the stall drops
module fb_pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              PC_STEP      = 4,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            pc_reset_n,
  fb_pc_gen_if.slave      bus
);

  if (XLEN < 16 || XLEN > 64) begin : g_bad_xlen
    $error("fb_pc_gen: XLEN must be within 16..64");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("fb_pc_gen: FLUSH_CYCLES must be within 1..15");
  end

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
  localparam logic [3:0]      BUBBLE_LEN = 4'(FLUSH_CYCLES);

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_addr_q;
  logic [3:0]      bubble_q;
  logic            clear_q;
  logic            pending_q;

  logic            apply_redirect;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic [3:0]      bubble_nxt;

`ifdef FB_PC_ALIGN_CHECK_EN
  localparam bit ALIGN_ACTIVE = (PC_STEP == 4);
  logic misalign_q;
  logic misalign_nxt;
`endif

  // A live redirect always beats the buffered one, so a stall release with a
  // fresh request takes the fresh address.
  always_comb begin
    apply_redirect = !bus.pc_stall && (bus.redirect_valid || (state == ST_PEND));
    raw_target     = bus.redirect_valid ? bus.redirect_addr : pend_addr_q;
`ifdef FB_PC_ALIGN_CHECK_EN
    misalign_nxt   = ALIGN_ACTIVE && apply_redirect && (raw_target[1:0] != 2'b00);
    target         = ALIGN_ACTIVE ? {raw_target[XLEN-1:2], 2'b00} : raw_target;
`else
    target         = raw_target;
`endif
  end

  // Retriggering reloads rather than accumulates; stall does not freeze the count.
  always_comb begin
    bubble_nxt = bubble_q;
    if (apply_redirect || bus.flush) begin
      bubble_nxt = BUBBLE_LEN;
    end else if (bubble_q != 4'd0) begin
      bubble_nxt = bubble_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      state       <= ST_RUN;
      pc_q        <= RESET_VECTOR;
      pend_addr_q <= '0;
      bubble_q    <= 4'd0;
      clear_q     <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.redirect_valid && bus.pc_stall) begin
            pend_addr_q <= bus.redirect_addr;
            pending_q   <= 1'b1;
            state       <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (bus.pc_stall) begin
            if (bus.redirect_valid) begin
              pend_addr_q <= bus.redirect_addr;
            end
          end else begin
            pending_q <= 1'b0;
            state     <= ST_RUN;
          end
        end
        default: begin
          pending_q <= 1'b0;
          state     <= ST_RUN;
        end
      endcase

      if (apply_redirect) begin
        pc_q <= target;
      end else if (!bus.pc_stall) begin
        pc_q <= pc_q + STEP;
      end

      bubble_q <= bubble_nxt;
      clear_q  <= (bubble_nxt != 4'd0);
    end
  end

`ifdef FB_PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_nxt;
    end
  end

  assign bus.misalign_err = misalign_q;
`endif

  assign bus.pc_out           = pc_q;
  assign bus.pc_next_seq      = pc_q + STEP;
  assign bus.clear_inst       = clear_q;
  assign bus.redirect_pending = pending_q;

endmodule

// File: doc/fb_pc_gen.md
Name: fb_pc_gen

Overview:
Parametrised program-counter unit for the Firebird pipeline IF stage. It supersedes the fixed 32-bit PC register with:
- a configurable reset vector and sequential step;
- prioritised redirect, stall and flush handling;
- a pending-redirect buffer so a redirect raised during a stall is never lost;
- a programmable bubble counter that drives clear_inst for N cycles after any control-flow change.

Parameters:
XLEN, 32, address width in bits (16..64).
RESET_VECTOR, 0, pc_out value after reset (XLEN bits).
PC_STEP, 4, sequential increment; 4 = byte-addressed memory, 1 = word-indexed ROM.
FLUSH_CYCLES, 1, number of clear_inst cycles per redirect/flush (1..15).

Ports:
clk  input  1  rising-edge clock.
pc_reset_n  input  1  asynchronous active-low reset.
pc_stall  input  1  hazard hold; pc_out keeps its value.
redirect_valid  input  1  one-cycle request to load redirect_addr (branch/jal/jalr).
redirect_addr  input  XLEN  redirect target.
flush  input  1  insert bubbles without changing PC.
pc_out  output  XLEN  current fetch address.
pc_next_seq  output  XLEN  combinational pc_out+PC_STEP, modulo 2^XLEN (link value).
clear_inst  output  1  registered; 1 = IF instruction must be replaced by NOP.
redirect_pending  output  1  registered; a buffered redirect is waiting for the stall to drop.

Behaviour:
- Reset (pc_reset_n=0, asynchronous, any cycle): pc_out=RESET_VECTOR, clear_inst=0, redirect_pending=0, bubble counter=0, FSM=RUN, pending address=0. The first post-reset edge with no stall loads pc_out=RESET_VECTOR+PC_STEP.
- PC update priority per edge, highest first:
  1. Reset.
  2. Redirect applied (see FSM): pc_out<=target.
  3. pc_stall=1: hold.
  4. Otherwise: pc_out<=pc_out+PC_STEP, wrapping at 2^XLEN.
- FSM has two states:
  - RUN, redirect_valid & !pc_stall: load redirect_addr on this edge and start bubbles. Stay in RUN.
  - RUN, redirect_valid & pc_stall: capture redirect_addr into the pending register, set redirect_pending=1, go to PEND. PC holds.
  - PEND, pc_stall=1: hold. A new redirect_valid overwrites the pending address (latest wins).
  - PEND, pc_stall=0: load the target on this edge and start bubbles, clearing redirect_pending, go to RUN. If redirect_valid is also asserted on this cycle, redirect_addr wins over the buffered address.
- Bubble counter (4 bits):
  - Loaded with FLUSH_CYCLES on the edge where a redirect is applied or flush=1 is sampled.
  - Decrements by 1 each edge while nonzero, regardless of pc_stall.
  - clear_inst is registered: it is 1 in the cycles where the counter is nonzero. Latency from the triggering edge is 0 cycles, i.e. clear_inst=1 in the cycle immediately after the edge.
  - A new trigger while the counter is nonzero reloads FLUSH_CYCLES; it does not accumulate.
- flush and redirect on the same edge: a single reload of the counter.
- flush with pc_stall=1: counter loads; PC still holds.
- Latency: redirect_valid sampled at edge N gives pc_out=target after edge N, when not stalled.
- Reset asserted mid-PEND or mid-bubble: pending address and counter are discarded immediately.
- pc_next_seq is pure combinational from pc_out; it is not affected by stall or redirect.

Optional Feature:
- Macro: FB_PC_ALIGN_CHECK_EN.
- Defined:
  - Adds output port misalign_err (1 bit, registered, reset 0).
  - When a redirect is applied and PC_STEP=4 and target[1:0]!=0, misalign_err pulses 1 for exactly one cycle.
  - The PC is loaded with target[1:0] forced to 2'b00.
  - For PC_STEP!=4 the check is disabled and misalign_err stays 0.
- Undefined: the port is absent and targets are loaded unmodified.

Test Plan:
1. Defaults; release reset, 3 unstalled edges -> pc_out sequence 0x0, 0x4, 0x8, 0xC; clear_inst=0 throughout.
2. pc_out=0x10; redirect_valid=1 with redirect_addr=0x80, no stall -> next cycle pc_out=0x80 and clear_inst=1 for 1 cycle; then pc_out=0x84 with clear_inst=0.
3. pc_stall=1 for 3 cycles at pc_out=0x20. Redirects occur in stall cycle 1 (0x100) and stall cycle 2 (0x200):
   - redirect_pending=1 from the cycle after the first redirect;
   - stall drops -> pc_out=0x200 and redirect_pending=0.
4. FLUSH_CYCLES=3; flush at pc_out=0x40 -> clear_inst=1 for 3 cycles while pc_out advances 0x44, 0x48, 0x4C. A second flush in bubble cycle 2 extends clear_inst=1 to 3 more cycles.
5. XLEN=16, PC_STEP=1, RESET_VECTOR=0xFFFE -> pc_out 0xFFFE, 0xFFFF, 0x0000 (wrap).
6. With FB_PC_ALIGN_CHECK_EN: redirect to 0x103 -> pc_out=0x100 and misalign_err=1 for one cycle. Separately, assert pc_reset_n=0 while in PEND -> pc_out=RESET_VECTOR and redirect_pending=0 immediately, with no clock edge.
